// File: rtl/mdu_div.sv
// mdu_div: iterative radix-2 restoring divider for the MDU (MIPS div/divu).
//
// Quotient goes to LO, remainder to HI. Control starts an operation with a
// one-cycle (or longer) start while the block is idle and stalls the pipeline
// while busy is high.
//
// Handshake: start is sampled only in IDLE; a, b and is_signed are captured
// on that edge and are don't-care afterwards. busy is high from the cycle
// after acceptance until the cycle done pulses; done is a one-cycle pulse and
// quotient/remainder are valid from that cycle and held until the next
// accepted start. busy and done are never high together.
//
// Ports:
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   start      divide request (IDLE only)
//   is_signed  1 = div (two's complement), 0 = divu
//   a, b       dividend, divisor
//   busy       operation in flight
//   done       result pulse
//   quotient   LO result
//   remainder  HI result
//
// Optional build macro DIV_EARLY_TERM_EN: when |a| < |b| (b != 0) the CALC
// phase is skipped and the result (q = 0, r = a) is produced one edge later.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem;       // partial remainder (always < divisor, or |a| when b==0)
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] a_raw;     // original dividend, returned as remainder when b==0
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  // Magnitudes; the most negative value maps to itself read as unsigned.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  // One restoring step on a WIDTH+1 bit window; trial[WIDTH] is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             last_iter;

  always_comb begin
    abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    shifted   = {rem, dvd[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

`ifdef DIV_EARLY_TERM_EN
  logic early;
  always_comb begin
    early = (b != '0) && (abs_a < abs_b);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      rem       <= '0;
      divisor   <= '0;
      a_raw     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            divisor  <= abs_b;
            a_raw    <= a;
            div_zero <= (b == '0);
            // b==0 returns the raw restoring result, so no sign fix then.
            q_neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            r_neg    <= is_signed && a[WIDTH-1];
            cnt      <= '0;
            busy     <= 1'b1;
`ifdef DIV_EARLY_TERM_EN
            if (early) begin
              // Quotient 0; remainder |a| gets its sign restored in FIX.
              dvd   <= '0;
              rem   <= abs_a;
              state <= FIX;
            end else begin
              dvd   <= abs_a;
              rem   <= '0;
              state <= CALC;
            end
`else
            dvd   <= abs_a;
            rem   <= '0;
            state <= CALC;
`endif
          end
        end

        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient  <= q_neg ? (~dvd + 1'b1) : dvd;
          if (div_zero) begin
            remainder <= a_raw;
          end else begin
            remainder <= r_neg ? (~rem + 1'b1) : rem;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
module tb_mdu_div;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_tests;
  int n_fail;

  mdu_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on wide signed/unsigned integers.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic s, output logic [W-1:0] q,
                                output logic [W-1:0] r);
    longint sx, sy, lq, lr;
    if (y == 0) begin
      q = '1;
      r = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Edges after the accepting edge until done is seen.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint mx, my;
    mx = s ? longint'($signed(x)) : longint'({32'd0, x});
    my = s ? longint'($signed(y)) : longint'({32'd0, y});
    if (mx < 0) mx = -mx;
    if (my < 0) my = -my;
`ifdef DIV_EARLY_TERM_EN
    if (y != 0 && mx < my) return 1;
`endif
    return W + 1;
  endfunction

  // ---------------- driver ----------------
  // Issues one divide; pulse_at > 0 injects a stray start (9/4) during the
  // cycle following edge N+pulse_at, which must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input int pulse_at,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat);
    int  c;
    logic proto_ok;
    proto_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; is_signed = ts;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    if (busy !== 1'b1 || done !== 1'b0) proto_ok = 1'b0;
    c = 0;
    lat = -1;
    while (c < 100) begin
      if (c == pulse_at && pulse_at > 0) begin
        start = 1'b1; a = 32'd9; b = 32'd4; is_signed = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      c++;
      if (busy === 1'b1 && done === 1'b1) proto_ok = 1'b0;
      if (done === 1'b1) begin
        if (busy !== 1'b0) proto_ok = 1'b0;
        lat = c;
        break;
      end
      if (busy !== 1'b1) proto_ok = 1'b0;
    end
    q = quotient;
    r = remainder;
    chk("busy_done_protocol", {31'd0, proto_ok}, 32'd1);
    // Result must be held and the block idle on the following cycle.
    @(posedge clk);
    #1;
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    chk("q_held", quotient, q);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic [W-1:0] eq, input logic [W-1:0] er);
    logic [W-1:0] q, r;
    int lat;
    run_op(ta, tb_v, ts, 0, q, r, lat);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_lat"}, W'(lat), W'(exp_lat(ta, tb_v, ts)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] q, r, eq, er, ra, rb;
    logic         rs;
    int           lat;
    logic         saw_done;
    n_tests = 0;
    n_fail  = 0;
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    #12;
    chk("reset_out", {30'd0, busy, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    directed("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    directed("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    directed("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    directed("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    directed("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    directed("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
    directed("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    directed("div_0_3", 32'd0, 32'd3, 1'b1, 32'd0, 32'd0);
    directed("divu_3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3);
    directed("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD);

    // Stray start mid-operation and during FIX must both be ignored.
    run_op(32'd100, 32'd7, 1'b0, 10, q, r, lat);
    chk("stray_mid_q", q, 32'd14);
    chk("stray_mid_r", r, 32'd2);
    chk("stray_mid_lat", W'(lat), W'(W + 1));
    run_op(32'd100, 32'd7, 1'b0, W, q, r, lat);
    chk("stray_fix_q", q, 32'd14);
    chk("stray_fix_r", r, 32'd2);

    // Reset in the middle of CALC: immediate clear, no done.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {30'd0, busy, done}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
    directed("after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

    // Random pairs against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 15);
        1: ra = $urandom_range(0, 1000);
        2: begin
          rb = $urandom_range(1, 15);
          if (rs) rb = -rb;
        end
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) ra = 32'h8000_0000;
      if (rb == 0) rb = 32'd1;
      model(ra, rb, rs, eq, er);
      run_op(ra, rb, rs, 0, q, r, lat);
      chk("rand_q", q, eq);
      chk("rand_r", r, er);
      chk("rand_lat", W'(lat), W'(exp_lat(ra, rb, rs)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
